// File: rtl/psram_arb_pkg.sv
// psram_arb_pkg: shared state encoding and sizing helpers for the PSRAM Wishbone arbiter.
package psram_arb_pkg;
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t BUSY = 2'd1;
    localparam state_t GAP  = 2'd2;

    function automatic int sel_width(input int dw);
        return dw / 8;
    endfunction

    // At least one bit so a disabled watchdog still yields a legal vector.
    function automatic int timer_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; on a tie the master not served last wins.
module rr_arbiter2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt_valid,
    output logic gnt_idx
);
    assign gnt_valid = req0 | req1;
    assign gnt_idx   = (req0 & req1) ? ~last : req1;
endmodule

// File: rtl/psram_wb_arbiter.sv
// psram_wb_arbiter: shares one PSRAM Wishbone slave between fetch (m0) and data (m1) masters,
// with registered requests, a post-transaction idle gap and a per-transaction timeout.
module psram_wb_arbiter
    import psram_arb_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int GAP_CYCLES     = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [AW-1:0]              m0_adr_i,
    input  logic [DW-1:0]              m0_dat_i,
    input  logic [sel_width(DW)-1:0]   m0_sel_i,
    input  logic                       m0_we_i,
    input  logic                       m0_cyc_i,
    input  logic                       m0_stb_i,
    output logic [DW-1:0]              m0_dat_o,
    output logic                       m0_ack_o,
    output logic                       m0_err_o,
    input  logic [AW-1:0]              m1_adr_i,
    input  logic [DW-1:0]              m1_dat_i,
    input  logic [sel_width(DW)-1:0]   m1_sel_i,
    input  logic                       m1_we_i,
    input  logic                       m1_cyc_i,
    input  logic                       m1_stb_i,
    output logic [DW-1:0]              m1_dat_o,
    output logic                       m1_ack_o,
    output logic                       m1_err_o,
    output logic [AW-1:0]              s_adr_o,
    output logic [DW-1:0]              s_dat_o,
    output logic [sel_width(DW)-1:0]   s_sel_o,
    output logic                       s_we_o,
    output logic                       s_cyc_o,
    output logic                       s_stb_o,
    input  logic [DW-1:0]              s_dat_i,
    input  logic                       s_ack_i,
    output logic                       busy_o
);
    localparam int SW = sel_width(DW);
    localparam int TW = timer_width(TIMEOUT_CYCLES);

    state_t          state;
    logic            last, g, gnt_valid, gnt_idx, in_busy, ack_in, tmo;
    logic [TW-1:0]   timer;
    logic [3:0]      gap_cnt;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat;
    logic [SW-1:0]   sel;
    logic            we;

    rr_arbiter2 u_rr (
        .req0      (m0_cyc_i & m0_stb_i),
        .req1      (m1_cyc_i & m1_stb_i),
        .last      (last),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign in_busy = state == BUSY;
    assign ack_in  = in_busy & s_ack_i;
    // Ack beats a simultaneous timeout; a zero limit disables the watchdog.
    assign tmo     = in_busy & ~s_ack_i & (TIMEOUT_CYCLES != 0)
                     & ({{(32-TW){1'b0}}, timer} == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            last    <= 1'b1;
            g       <= 1'b0;
            timer   <= '0;
            gap_cnt <= '0;
            adr     <= '0;
            dat     <= '0;
            sel     <= '0;
            we      <= 1'b0;
        end else if (state == IDLE) begin
            if (gnt_valid) begin
                g     <= gnt_idx;
                adr   <= gnt_idx ? m1_adr_i : m0_adr_i;
                dat   <= gnt_idx ? m1_dat_i : m0_dat_i;
                sel   <= gnt_idx ? m1_sel_i : m0_sel_i;
                we    <= gnt_idx ? m1_we_i  : m0_we_i;
                timer <= '0;
                state <= BUSY;
            end
        end else if (in_busy) begin
            if (ack_in | tmo) begin
                last    <= g;
                gap_cnt <= '0;
                state   <= GAP;
            end else begin
                timer <= timer + TW'(1);
            end
        end else begin
            if (gap_cnt == 4'(GAP_CYCLES - 1)) state <= IDLE;
            else gap_cnt <= gap_cnt + 4'd1;
        end
    end

    assign s_adr_o  = adr;
    assign s_dat_o  = dat;
    assign s_sel_o  = sel;
    assign s_we_o   = we;
    assign s_cyc_o  = in_busy;
    assign s_stb_o  = in_busy;
    assign busy_o   = state != IDLE;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = ack_in & ~rst_i & ~g;
    assign m1_ack_o = ack_in & ~rst_i & g;
    assign m0_err_o = tmo & ~rst_i & ~g;
    assign m1_err_o = tmo & ~rst_i & g;
endmodule

// File: tb/tb_psram_wb_arbiter.sv
// tb_psram_wb_arbiter: directed scenarios with a transaction-level reference model checked every cycle.
module tb_psram_wb_arbiter;
    localparam int T = 8;
    localparam int G = 2;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] m0_adr = '0, m0_dat = '0, m1_adr = '0, m1_dat = '0, s_dat = '0;
    logic [3:0]  m0_sel = '0, m1_sel = '0;
    logic        m0_we = 1'b0, m0_cyc = 1'b0, m0_stb = 1'b0;
    logic        m1_we = 1'b0, m1_cyc = 1'b0, m1_stb = 1'b0, s_ack = 1'b0;
    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_we_o, s_cyc_o, s_stb_o, busy_o;

    always #5 clk = ~clk;

    psram_wb_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(T), .GAP_CYCLES(G)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat), .s_ack_i(s_ack), .busy_o(busy_o)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the slave, how long it has held it, and how much cool-down remains.
    int          own = -1, age = 0, cool = 0, mlast = 1;
    logic [31:0] e_adr = '0, e_dat = '0;
    logic [3:0]  e_sel = '0;
    logic        e_we = 1'b0;
    bit          chk_en = 1'b0;
    logic        r0, r1;
    assign r0 = m0_cyc & m0_stb;
    assign r1 = m1_cyc & m1_stb;

    function automatic int pick(input logic a, input logic b, input int lst);
        return (a && b) ? 1 - lst : (a ? 0 : 1);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            own    <= -1;
            age    <= 0;
            cool   <= 0;
            mlast  <= 1;
            chk_en <= 1'b1;
        end else if (own >= 0) begin
            if (s_ack || age == T - 1) begin
                mlast <= own;
                own   <= -1;
                cool  <= G;
            end else age <= age + 1;
        end else if (cool > 0) cool <= cool - 1;
        else if (r0 || r1) begin
            own   <= pick(r0, r1, mlast);
            age   <= 0;
            e_adr <= (pick(r0, r1, mlast) == 1) ? m1_adr : m0_adr;
            e_dat <= (pick(r0, r1, mlast) == 1) ? m1_dat : m0_dat;
            e_sel <= (pick(r0, r1, mlast) == 1) ? m1_sel : m0_sel;
            e_we  <= (pick(r0, r1, mlast) == 1) ? m1_we  : m0_we;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy_o", busy_o, own >= 0 || cool > 0);
            chk("s_cyc_o", s_cyc_o, own >= 0);
            chk("s_stb_o", s_stb_o, own >= 0);
            if (own >= 0) begin
                chk("s_adr_o", s_adr_o, e_adr);
                chk("s_dat_o", s_dat_o, e_dat);
                chk("s_sel_o", s_sel_o, e_sel);
                chk("s_we_o", s_we_o, e_we);
            end
            chk("m0_ack_o", m0_ack_o, own == 0 && s_ack && !rst);
            chk("m1_ack_o", m1_ack_o, own == 1 && s_ack && !rst);
            chk("m0_err_o", m0_err_o, own == 0 && !s_ack && !rst && age == T - 1);
            chk("m1_err_o", m1_err_o, own == 1 && !s_ack && !rst && age == T - 1);
            chk("m0_dat_o", m0_dat_o, s_dat);
            chk("m1_dat_o", m1_dat_o, s_dat);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_stb;
        int n = 0;
        while (!s_stb_o && n < 50) begin
            step;
            n++;
        end
        chk("stb_wait", s_stb_o, 1);
    endtask

    task automatic req0(input logic on, input logic [31:0] a);
        m0_adr = a; m0_cyc = on; m0_stb = on;
    endtask

    task automatic req1(input logic on, input logic [31:0] a);
        m1_adr = a; m1_cyc = on; m1_stb = on;
    endtask

    int got[4];
    int exp_ord[4] = '{0, 1, 0, 1};
    int errs, err_at, acks;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m0_sel = 4'hf; m1_sel = 4'hf;
        repeat (2) step;
        rst = 1'b0;
        chk("rst_busy", busy_o, 0);
        chk("rst_cyc", s_cyc_o, 0);

        // m0 read, slave answers 5 cycles after strobe
        req0(1, 32'h40);
        step;
        chk("t1_stb_latency", s_stb_o, 1);
        chk("t1_adr", s_adr_o, 32'h40);
        repeat (5) step;
        s_ack = 1'b1; s_dat = 32'hDEADBEEF;
        #1;
        chk("t1_m0_ack", m0_ack_o, 1);
        chk("t1_m0_dat", m0_dat_o, 32'hDEADBEEF);
        chk("t1_m1_ack", m1_ack_o, 0);
        step;
        s_ack = 1'b0; req0(0, 32'h40);
        for (int i = 0; i < G; i++) begin
            chk("t1_gap_cyc", s_cyc_o, 0);
            chk("t1_gap_busy", busy_o, 1);
            step;
        end
        chk("t1_idle", busy_o, 0);

        // tie after reset then continuous contention
        rst = 1'b1; step; rst = 1'b0;
        req0(1, 32'h200); req1(1, 32'h300);
        for (int t = 0; t < 4; t++) begin
            wait_stb;
            step;
            s_ack = 1'b1;
            #1;
            got[t] = m1_ack_o ? 1 : (m0_ack_o ? 0 : 9);
            step;
            s_ack = 1'b0;
        end
        req0(0, 32'h0); req1(0, 32'h0);
        for (int t = 0; t < 4; t++) chk("t2_order", got[t], exp_ord[t]);
        repeat (G + 1) step;

        // m1 write; master scribbles on its bus after the grant
        req1(1, 32'h100); m1_dat = 32'h12345678; m1_sel = 4'b0011; m1_we = 1'b1;
        wait_stb;
        m1_adr = 32'hFFFF0000; m1_dat = 32'h0; m1_sel = 4'hf; m1_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t3_adr", s_adr_o, 32'h100);
            chk("t3_dat", s_dat_o, 32'h12345678);
            chk("t3_sel", s_sel_o, 4'b0011);
            chk("t3_we", s_we_o, 1);
            step;
        end
        s_ack = 1'b1;
        #1;
        chk("t3_m1_ack", m1_ack_o, 1);
        step;
        s_ack = 1'b0; req1(0, 32'h0);
        repeat (G + 1) step;

        // timeout on m0 with m1 waiting
        req0(1, 32'h500);
        step;
        req1(1, 32'h600);
        wait_stb;
        errs = 0; err_at = 0; acks = 0;
        for (int i = 1; i <= 10; i++) begin
            if (m0_err_o) begin
                errs++;
                err_at = i;
                req0(0, 32'h0);
            end
            acks += int'(m0_ack_o);
            step;
        end
        chk("t4_err_pulses", errs, 1);
        chk("t4_err_cycle", err_at, 8);
        chk("t4_no_ack", acks, 0);
        wait_stb;
        chk("t4_next_adr", s_adr_o, 32'h600);
        s_ack = 1'b1;
        #1;
        chk("t4_m1_ack", m1_ack_o, 1);
        step;
        s_ack = 1'b0; req1(0, 32'h0);
        repeat (G + 1) step;

        // ack on the very cycle the watchdog would fire
        req0(1, 32'h700);
        step;
        repeat (T - 1) step;
        s_ack = 1'b1;
        #1;
        chk("t5_ack_wins", m0_ack_o, 1);
        chk("t5_no_err", m0_err_o, 0);
        step;
        s_ack = 1'b0; req0(0, 32'h0);
        repeat (G + 1) step;
        chk("t5_idle", busy_o, 0);
        s_ack = 1'b1;
        #1;
        chk("t5_spur_m0", m0_ack_o, 0);
        chk("t5_spur_m1", m1_ack_o, 0);
        step;
        s_ack = 1'b0;

        // reset in the middle of a transaction, then a fresh tie
        req1(1, 32'h800);
        wait_stb;
        repeat (2) step;
        rst = 1'b1; req1(0, 32'h0);
        step;
        rst = 1'b0;
        chk("t6_cyc", s_cyc_o, 0);
        chk("t6_busy", busy_o, 0);
        chk("t6_m1_ack", m1_ack_o, 0);
        chk("t6_m1_err", m1_err_o, 0);
        req0(1, 32'h900); req1(1, 32'hA00);
        wait_stb;
        chk("t6_tie_m0", s_adr_o, 32'h900);
        s_ack = 1'b1;
        #1;
        chk("t6_m0_ack", m0_ack_o, 1);
        step;
        s_ack = 1'b0; req0(0, 32'h0); req1(0, 32'h0);
        repeat (4) step;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
